rle_image_encoder: RTL and testbench

//  Streaming run-length encoder for raster images, the write side of the *_rom image lookups.

---
 rtl/vga_img_pkg.sv | 20 ++
 rtl/rle_out_reg.sv | 45 ++++
 rtl/rle_image_encoder.sv | 150 +++++++++++++++
 tb/tb_rle_image_encoder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_img_pkg.sv
// Shared image constants and encoder state type.
//   COLOR_W            pixel colour width (4:4:4 RGB)
//   IMG_W_DEF/IMG_H_DEF default frame geometry
//   WHITE/BLACK        common colours
//   enc_state_t        run-length encoder FSM states
package vga_img_pkg;
  localparam int COLOR_W   = 12;
  localparam int IMG_W_DEF = 584;
  localparam int IMG_H_DEF = 167;
  localparam logic [COLOR_W-1:0] WHITE = 12'hFFF;
  localparam logic [COLOR_W-1:0] BLACK = 12'h000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FIRST = 3'd1,
    ST_ACCUM = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4
  } enc_state_t;
endpackage

// File: rtl/rle_out_reg.sv
// One-entry valid/ready holding register for an RLE record.
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     load side; in_ready = empty or draining this cycle
//   in_start/end/color/last  record to load
//   out_valid/out_ready   sink side handshake
//   out_start/end/color/last record held for the sink
module rle_out_reg #(
  parameter int ADDR_W  = 17,
  parameter int COLOR_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_start,
  input  logic [ADDR_W-1:0]  in_end,
  input  logic [COLOR_W-1:0] in_color,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_start,
  output logic [ADDR_W-1:0]  out_end,
  output logic [COLOR_W-1:0] out_color,
  output logic               out_last
);
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_start <= '0;
      out_end   <= '0;
      out_color <= '0;
      out_last  <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_start <= in_start;
      out_end   <= in_end;
      out_color <= in_color;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/rle_image_encoder.sv
// Streaming run-length encoder for raster images. Pixels arrive in raster
// order; records {start, end, color} describe inclusive linear-address runs.
//   clk, rst_n                 clock, async active-low reset
//   start                      pulse to begin a frame (ignored while busy)
//   pix_valid/pix_ready/pix_color  pixel stream
//   run_valid/run_ready        record stream handshake
//   run_start/run_end/run_color/run_last  record fields
//   run_count                  records handshaken this frame
//   busy, done                 frame in progress / 1-cycle end-of-frame pulse
//
// state | meaning
// IDLE  | waiting for start
// FIRST | accepting pixel 0, opens the first run
// ACCUM | extending or closing runs, one pixel per cycle
// FLUSH | last pixel taken, pushing the final run into the output register
// DRAIN | waiting for the final record to handshake
module rle_image_encoder #(
  parameter int IMG_W   = vga_img_pkg::IMG_W_DEF,
  parameter int IMG_H   = vga_img_pkg::IMG_H_DEF,
  parameter int COLOR_W = vga_img_pkg::COLOR_W,
  parameter int ADDR_W  = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [COLOR_W-1:0] pix_color,
  output logic               run_valid,
  input  logic               run_ready,
  output logic [ADDR_W-1:0]  run_start,
  output logic [ADDR_W-1:0]  run_end,
  output logic [COLOR_W-1:0] run_color,
  output logic               run_last,
  output logic [ADDR_W-1:0]  run_count,
  output logic               busy,
  output logic               done
);
  import vga_img_pkg::*;

  localparam int TOTAL = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

  enc_state_t         r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_cur_start;
  logic [ADDR_W-1:0]  r_cur_end;
  logic [COLOR_W-1:0] r_cur_color;

  logic w_accept;
  logic w_color_diff;
  logic w_load;
  logic w_load_last;
  logic w_out_in_ready;
  logic w_run_fire;

  // In ACCUM a pixel is only taken when the output register can absorb a
  // closing run in the same cycle, which keeps the datapath single-entry.
  always_comb begin
    pix_ready = 1'b0;
    case (r_state)
      ST_FIRST: pix_ready = 1'b1;
      ST_ACCUM: pix_ready = w_out_in_ready;
      default:  pix_ready = 1'b0;
    endcase
  end

  assign w_accept     = pix_valid && pix_ready;
  assign w_color_diff = (pix_color != r_cur_color);
  assign w_load_last  = (r_state == ST_FLUSH);
  assign w_load       = ((r_state == ST_ACCUM) && w_accept && w_color_diff) || w_load_last;
  assign w_run_fire   = run_valid && run_ready;

  rle_out_reg #(
    .ADDR_W  (ADDR_W),
    .COLOR_W (COLOR_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_load),
    .in_ready  (w_out_in_ready),
    .in_start  (r_cur_start),
    .in_end    (r_cur_end),
    .in_color  (r_cur_color),
    .in_last   (w_load_last),
    .out_valid (run_valid),
    .out_ready (run_ready),
    .out_start (run_start),
    .out_end   (run_end),
    .out_color (run_color),
    .out_last  (run_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_cur_start <= '0;
      r_cur_end   <= '0;
      r_cur_color <= '0;
      run_count   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_run_fire) run_count <= run_count + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr    <= '0;
            run_count <= '0;
            busy      <= 1'b1;
            r_state   <= ST_FIRST;
          end
        end
        ST_FIRST: begin
          if (w_accept) begin
            r_cur_start <= '0;
            r_cur_end   <= '0;
            r_cur_color <= pix_color;
            r_addr      <= ADDR_W'(1);
            r_state     <= (TOTAL == 1) ? ST_FLUSH : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            r_addr <= r_addr + 1'b1;
            if (w_color_diff) begin
              r_cur_start <= r_addr;
              r_cur_color <= pix_color;
            end
            r_cur_end <= r_addr;
            if (r_addr == LAST_ADDR) r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (w_out_in_ready) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_run_fire) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rle_image_encoder.sv
module tb_rle_image_encoder;
  import vga_img_pkg::*;

  localparam int W  = 8;
  localparam int H  = 2;
  localparam int T  = W * H;
  localparam int AW = 17;
  localparam int CW = 12;

  typedef struct packed {
    logic [AW-1:0] s;
    logic [AW-1:0] e;
    logic [CW-1:0] c;
    logic          l;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [CW-1:0] pix_color = '0;
  logic          run_valid;
  logic          run_ready = 1'b1;
  logic [AW-1:0] run_start, run_end, run_count;
  logic [CW-1:0] run_color;
  logic          run_last, busy, done;

  rle_image_encoder #(.IMG_W(W), .IMG_H(H), .COLOR_W(CW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_color(pix_color),
    .run_valid(run_valid), .run_ready(run_ready),
    .run_start(run_start), .run_end(run_end), .run_color(run_color),
    .run_last(run_last), .run_count(run_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [CW-1:0] frame [T];
  rec_t exp_q[$];
  int   hs_cnt = 0;
  int   stall_left = 0;
  int   first_acc, last_acc;
  bit   held = 0;
  rec_t held_rec;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the frame and cut a run wherever the colour changes.
  function automatic void build_model();
    int s;
    rec_t r;
    exp_q.delete();
    s = 0;
    for (int a = 1; a <= T; a++) begin
      bit cut;
      cut = (a == T);
      if (!cut) cut = (frame[a] != frame[s]);
      if (cut) begin
        r.s = AW'(s); r.e = AW'(a - 1); r.c = frame[s]; r.l = (a == T);
        exp_q.push_back(r);
        s = a;
      end
    end
  endfunction

  // Sink-side back-pressure: stall the first stall_left valid cycles.
  always @(posedge clk) begin
    #1;
    if (stall_left > 0 && run_valid) begin
      run_ready = 1'b0;
      stall_left--;
    end else begin
      run_ready = 1'b1;
    end
  end

  // Compare process: every record handshake against the model queue.
  always @(negedge clk) begin
    rec_t cur;
    cur = '{run_start, run_end, run_color, run_last};
    if (!rst_n) begin
      held = 0;
    end else begin
      if (run_valid && !run_ready) chk("pix_ready_while_full", 64'(pix_ready), 64'd0);
      if (held) begin
        chk("held_valid", 64'(run_valid), 64'd1);
        chk("held_record", 64'(cur), 64'(held_rec));
      end
      held = run_valid && !run_ready;
      held_rec = cur;
      if (run_valid && run_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_record", 64'(cur), 64'd0);
          if (cur == '0) chk("unexpected_record_nonzero", 64'd1, 64'd0);
        end else begin
          chk("record", 64'(cur), 64'(exp_q[0]));
          chk("run_count_at_hs", 64'(run_count), 64'(hs_cnt));
          void'(exp_q.pop_front());
          hs_cnt++;
        end
      end
    end
  end

  task automatic start_frame();
    build_model();
    hs_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("run_count_cleared", 64'(run_count), 64'd0);
  endtask

  task automatic send_frame(input int stop_at);
    int i, cyc;
    bit acc;
    i = 0; cyc = 0; first_acc = -1; last_acc = -1;
    pix_valid = 1'b1;
    pix_color = frame[0];
    while (i < T && i != stop_at && cyc < 300) begin
      @(negedge clk); acc = pix_ready;
      @(posedge clk); #1;
      if (acc) begin
        if (i == 0) first_acc = cyc;
        last_acc = cyc;
        i++;
      end
      cyc++;
      if (i < T) pix_color = frame[i];
    end
    pix_valid = 1'b0;
    if (cyc >= 300) chk("pixel_timeout", 64'(i), 64'(T));
  endtask

  task automatic wait_done(input int n_rec);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
    end while (!done && cyc < 100);
    chk("done_seen", 64'(done), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("run_count_final", 64'(run_count), 64'(n_rec));
    chk("model_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic fill(input int a, input int b, input logic [CW-1:0] c);
    for (int k = a; k <= b; k++) frame[k] = c;
  endtask

  initial begin
    #12;
    chk("rst_pix_ready", 64'(pix_ready), 64'd0);
    chk("rst_outputs", 64'({run_valid, run_last, busy, done, run_start, run_end, run_color, run_count}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single-colour frame; final record 2 cycles after last accept.
    fill(0, 15, WHITE);
    start_frame();
    chk("m1_size", 64'(exp_q.size()), 64'd1);
    chk("m1_rec", 64'(exp_q[0]), 64'({17'd0, 17'd15, 12'hFFF, 1'b1}));
    send_frame(-1);
    @(negedge clk); chk("c1_lat_cycle1", 64'(run_valid), 64'd0);
    @(negedge clk); chk("c1_lat_cycle2", 64'(run_valid), 64'd1);
    wait_done(1);

    // 2: three runs, with a redundant start while busy.
    fill(0, 4, WHITE); fill(5, 7, 12'h62F); fill(8, 15, WHITE);
    start_frame();
    chk("m2_size", 64'(exp_q.size()), 64'd3);
    chk("m2_rec1", 64'(exp_q[1]), 64'({17'd5, 17'd7, 12'h62F, 1'b0}));
    chk("m2_rec2", 64'(exp_q[2]), 64'({17'd8, 17'd15, 12'hFFF, 1'b1}));
    fork
      send_frame(-1);
      begin
        repeat (7) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    join
    wait_done(3);

    // 3: colour change on the last pixel; first record 1 cycle after.
    fill(0, 14, WHITE); fill(15, 15, BLACK);
    start_frame();
    chk("m3_rec1", 64'(exp_q[1]), 64'({17'd15, 17'd15, 12'h000, 1'b1}));
    send_frame(-1);
    @(negedge clk);
    chk("c3_lat", 64'(run_valid), 64'd1);
    chk("c3_first_last", 64'(run_last), 64'd0);
    wait_done(2);

    // 4: case 2 with a 5-cycle sink stall at the first record.
    fill(0, 4, WHITE); fill(5, 7, 12'h62F); fill(8, 15, WHITE);
    start_frame();
    stall_left = 5;
    send_frame(-1);
    chk("c4_stall_slowed", 64'(last_acc - first_acc >= 20), 64'd1);
    wait_done(3);

    // 5: alternating colour, one pixel per cycle sustained.
    for (int k = 0; k < T; k++) frame[k] = k[0] ? BLACK : WHITE;
    start_frame();
    chk("m5_size", 64'(exp_q.size()), 64'd16);
    send_frame(-1);
    chk("c5_throughput", 64'(last_acc - first_acc), 64'd15);
    wait_done(16);

    // 6: reset mid-frame, then a clean single-colour frame.
    fill(0, 4, WHITE); fill(5, 7, 12'h62F); fill(8, 15, WHITE);
    start_frame();
    send_frame(9);
    #2 rst_n = 1'b0;
    #1;
    chk("c6_rst_pix_ready", 64'(pix_ready), 64'd0);
    chk("c6_rst_outputs", 64'({run_valid, run_last, busy, done, run_start, run_end, run_color, run_count}), 64'd0);
    exp_q.delete();
    #10 rst_n = 1'b1;
    fill(0, 15, WHITE);
    start_frame();
    send_frame(-1);
    wait_done(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
